sar_oversampler: RTL and testbench

Conversion sequencer and result accumulator sitting directly downstream of the generic SAR ADC digital core. Issues start-of-conversion requests, detects end of conversion, and captures each result code. Accumulates 2**OSR_LOG2 consecutive codes and presents one averaged result through a valid/ready handshake to the register or DMA layer. Also flags comparator errors, overflow warnings and conversion timeouts seen during the burst.

---
 rtl/sar_oversampler_if.sv | 34 +++
 rtl/sar_oversampler.sv | 183 ++++++++++++++++++
 tb/tb_sar_oversampler.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sar_oversampler_if.sv
// Result port of the SAR oversampler: averaged code, raw sum, sticky flags
// and the valid/ready pair towards the register or DMA layer.
//
// Handshake: the producer raises res_valid together with avg_data, sum_data
// and res_flags, and holds all of them stable until a rising clock edge where
// res_valid && res_ready are both high. That edge completes the transfer.
// res_ready may be held high permanently. res_valid never depends
// combinationally on res_ready.
interface sar_oversampler_if #(
   parameter int NSTEP    = 10,
   parameter int OSR_LOG2 = 2
);
   logic [NSTEP-1:0]          avg_data;
   logic [NSTEP+OSR_LOG2-1:0] sum_data;
   logic [2:0]                res_flags;
   logic                      res_valid;
   logic                      res_ready;

   modport master (
      output avg_data,
      output sum_data,
      output res_flags,
      output res_valid,
      input  res_ready
   );

   modport slave (
      input  avg_data,
      input  sum_data,
      input  res_flags,
      input  res_valid,
      output res_ready
   );
endinterface

// File: rtl/sar_oversampler.sv
// Conversion sequencer and accumulator behind the SAR ADC core. Requests
// 2**OSR_LOG2 conversions per burst, sums the codes and offers one averaged
// result on the result interface. Sticky flags record comparator errors,
// counter overflows and conversion timeouts seen during the burst.
// Optional build macro SAR_AVG_ROUND_EN: round-half-up the average, saturated
// to the code range; without it the average is truncated.
module sar_oversampler #(
   parameter int NSTEP    = 10,
   parameter int OSR_LOG2 = 2,
   parameter int TIMEOUT  = 255
) (
   input  logic             f100m_clk,
   input  logic             rst,
   input  logic             start,
   input  logic             continuous,
   output logic             busy,
   output logic             sar_soc,
   input  logic             sar_eoc,
   input  logic             sar_err,
   input  logic             sar_warn,
   input  logic [NSTEP-1:0] sar_code,
   sar_oversampler_if.master res,
   output logic [2:0]       state_dbg
);

   localparam int AW = NSTEP + OSR_LOG2;
   localparam int CW = OSR_LOG2 + 1;
   localparam logic [CW-1:0] NSAMP    = CW'(1 << OSR_LOG2);
   localparam logic [9:0]    TMO_LAST = 10'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_BUSY    = 3'd2,
      S_CAPTURE = 3'd3,
      S_OUT     = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [9:0]        tmo_q, tmo_d;
   logic [2:0]        flags_q, flags_d;
   logic              eoc_q;
   logic [AW-1:0]     sum_q;
   logic [NSTEP-1:0]  avg_q;
   logic [NSTEP-1:0]  avg_calc;
   logic              valid_q;
   logic              accept;
   logic              load_out;

   assign accept   = valid_q & res.res_ready;
   assign load_out = (state_d == S_OUT) && (state_q != S_OUT);

   // Next-state, burst bookkeeping and sticky flag accumulation
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      flags_d = flags_q;
      if (state_q == S_REQ || state_q == S_BUSY || state_q == S_CAPTURE) begin
         flags_d[0] = flags_q[0] | sar_err;
         flags_d[1] = flags_q[1] | sar_warn;
      end
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_REQ;
               acc_d   = '0;
               cnt_d   = '0;
               tmo_d   = '0;
               flags_d = '0;
            end
         end
         S_REQ, S_BUSY: begin
            tmo_d = tmo_q + 10'd1;
            // This cycle is the TIMEOUT-th one spent waiting: give up on the
            // conversion and report the partial sum.
            if (tmo_q == TMO_LAST) begin
               state_d    = S_OUT;
               flags_d[2] = 1'b1;
            end else if (state_q == S_REQ && !sar_eoc) begin
               state_d = S_BUSY;
            end else if (state_q == S_BUSY && sar_eoc && !eoc_q) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            acc_d = acc_q + AW'(sar_code);
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == NSAMP) begin
               state_d = S_OUT;
            end else begin
               state_d = S_REQ;
               tmo_d   = '0;
            end
         end
         S_OUT: begin
            if (accept) begin
               if (continuous) begin
                  state_d = S_REQ;
                  acc_d   = '0;
                  cnt_d   = '0;
                  tmo_d   = '0;
                  flags_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Average of the accumulator value that is about to be latched
`ifdef SAR_AVG_ROUND_EN
   if (OSR_LOG2 == 0) begin : g_no_round
      assign avg_calc = acc_d[NSTEP-1:0];
   end else begin : g_round
      localparam logic [AW:0] HALF = (AW+1)'(1) << (OSR_LOG2 - 1);
      localparam logic [AW:0] MAXV = (AW+1)'((1 << NSTEP) - 1);
      logic [AW:0] rnd_sum;
      logic [AW:0] rnd_shift;
      assign rnd_sum   = {1'b0, acc_d} + HALF;
      assign rnd_shift = rnd_sum >> OSR_LOG2;
      assign avg_calc  = (rnd_shift > MAXV) ? {NSTEP{1'b1}} : rnd_shift[NSTEP-1:0];
   end
`else
   assign avg_calc = acc_d[AW-1:OSR_LOG2];
`endif

   // FSM state register and burst counters
   always_ff @(posedge f100m_clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         flags_q <= '0;
         eoc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         flags_q <= flags_d;
         eoc_q   <= sar_eoc;
      end
   end

   // Conversion request is high exactly while the FSM sits in REQ
   always_ff @(posedge f100m_clk or posedge rst) begin
      if (rst) begin
         sar_soc <= 1'b0;
      end else begin
         sar_soc <= (state_d == S_REQ);
      end
   end

   // Result registers: loaded on OUT entry, held until accepted
   always_ff @(posedge f100m_clk or posedge rst) begin
      if (rst) begin
         sum_q   <= '0;
         avg_q   <= '0;
         valid_q <= 1'b0;
      end else if (load_out) begin
         sum_q   <= acc_d;
         avg_q   <= avg_calc;
         valid_q <= 1'b1;
      end else if (accept) begin
         valid_q <= 1'b0;
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign state_dbg     = state_q;
   assign res.sum_data  = sum_q;
   assign res.avg_data  = avg_q;
   assign res.res_flags = flags_q;
   assign res.res_valid = valid_q;

endmodule

// File: tb/tb_sar_oversampler.sv
// Directed and randomized checks of sar_oversampler against a behavioural
// SAR model and an arithmetic reference for sum/average/flags.
module tb_sar_oversampler;

   localparam int NSTEP    = 10;
   localparam int OSR_LOG2 = 2;
   localparam int TIMEOUT  = 50;
   localparam int N_AVG    = 4;
   localparam int SW       = NSTEP + OSR_LOG2;
   localparam int W        = 3 + SW + NSTEP;

   logic             f100m_clk = 1'b0;
   logic             rst = 1'b1;
   logic             start;
   logic             continuous;
   logic             busy;
   logic             sar_soc;
   logic             sar_eoc;
   logic             sar_err;
   logic             sar_warn;
   logic [NSTEP-1:0] sar_code;
   logic [2:0]       state_dbg;

   sar_oversampler_if #(.NSTEP(NSTEP), .OSR_LOG2(OSR_LOG2)) res_if ();

   sar_oversampler #(
      .NSTEP   (NSTEP),
      .OSR_LOG2(OSR_LOG2),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .f100m_clk (f100m_clk),
      .rst       (rst),
      .start     (start),
      .continuous(continuous),
      .busy      (busy),
      .sar_soc   (sar_soc),
      .sar_eoc   (sar_eoc),
      .sar_err   (sar_err),
      .sar_warn  (sar_warn),
      .sar_code  (sar_code),
      .res       (res_if),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial forever #5 f100m_clk = ~f100m_clk;

   int cyc = 0;
   always @(posedge f100m_clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1);
   end

   // ---------------- sar_soc activity monitor ----------------
   int   soc_rises = 0;
   int   soc_run = 0;
   int   soc_last_run = 0;
   logic soc_prev = 1'b0;
   always @(posedge f100m_clk) begin
      soc_prev <= sar_soc;
      if (sar_soc && !soc_prev) soc_rises <= soc_rises + 1;
      if (sar_soc) begin
         soc_run <= soc_run + 1;
      end else begin
         if (soc_run > 0) soc_last_run <= soc_run;
         soc_run <= 0;
      end
   end

   // ---------------- behavioural SAR core ----------------
   int code_q[$];
   int served = 0;
   int hang_after = -1;
   int rise_cyc = 0;
   int sar_next;
   initial begin
      sar_eoc  = 1'b1;
      sar_code = '0;
      forever begin
         @(posedge f100m_clk); #1;
         if (!rst && sar_soc && sar_eoc && hang_after != 0) begin
            sar_next = (code_q.size() > 0) ? code_q.pop_front() : int'($urandom_range(0, 1023));
            if (hang_after > 0) hang_after--;
            served++;
            sar_eoc = 1'b0;
            for (int k = 0; k < 12 && !rst; k++) begin
               @(posedge f100m_clk); #1;
            end
            sar_code = NSTEP'(sar_next);
            sar_eoc  = 1'b1;
            rise_cyc = cyc;
         end
      end
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_avg(input int s);
      int r;
`ifdef SAR_AVG_ROUND_EN
      r = (s + N_AVG / 2) / N_AVG;
      if (r > 1023) r = 1023;
`else
      r = s / N_AVG;
`endif
      return r;
   endfunction

   task automatic push_burst(input int c0, input int c1, input int c2, input int c3,
                             input logic [2:0] fl);
      int s;
      code_q.push_back(c0);
      code_q.push_back(c1);
      code_q.push_back(c2);
      code_q.push_back(c3);
      s = c0 + c1 + c2 + c3;
      exp_q.push_back({fl, SW'(s), NSTEP'(ref_avg(s))});
   endtask

   // ---------------- driver tasks ----------------
   task automatic pulse_start();
      @(posedge f100m_clk); #1 start = 1'b1;
      @(posedge f100m_clk); #1 start = 1'b0;
   endtask

   task automatic accept_result();
      @(posedge f100m_clk); #1 res_if.res_ready = 1'b1;
      @(posedge f100m_clk); #1 res_if.res_ready = 1'b0;
      @(negedge f100m_clk);
   endtask

   task automatic wait_served(input int n);
      int k;
      k = 0;
      while (served < n && k < 600) begin
         @(negedge f100m_clk);
         k++;
      end
      check("served_reach", 32'(served >= n), 32'd1);
   endtask

   task automatic wait_result(input string tag, input bit chk_lat);
      logic [W-1:0] e;
      int k;
      k = 0;
      do begin
         @(negedge f100m_clk);
         k++;
      end while (!res_if.res_valid && k < 400);
      check({tag, "_valid"}, 32'(res_if.res_valid), 32'd1);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s_expect observed=result expected=none_queued", tag);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_sum"},   32'(res_if.sum_data),  32'(e[SW+NSTEP-1:NSTEP]));
         check({tag, "_avg"},   32'(res_if.avg_data),  32'(e[NSTEP-1:0]));
         check({tag, "_flags"}, 32'(res_if.res_flags), 32'(e[W-1:SW+NSTEP]));
         if (chk_lat) check({tag, "_latency"}, 32'(cyc - rise_cyc), 32'd2);
      end
   endtask

   // ---------------- directed sequence ----------------
   int base;
   int c[4];
   initial begin
      start = 1'b0;
      continuous = 1'b0;
      sar_err = 1'b0;
      sar_warn = 1'b0;
      res_if.res_ready = 1'b0;

      // reset state
      repeat (3) @(negedge f100m_clk);
      check("rst_soc",   32'(sar_soc), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_valid", 32'(res_if.res_valid), 32'd0);
      check("rst_sum",   32'(res_if.sum_data), 32'd0);
      check("rst_avg",   32'(res_if.avg_data), 32'd0);
      check("rst_flags", 32'(res_if.res_flags), 32'd0);
      @(posedge f100m_clk); #1 rst = 1'b0;
      repeat (2) @(posedge f100m_clk);

      // fixed burst 100..103, then held off for 20 cycles
      base = soc_rises;
      push_burst(100, 101, 102, 103, 3'b000);
      pulse_start();
      wait_result("t1", 1'b1);
      check("t1_soc_count", 32'(soc_rises - base), 32'd4);
      repeat (20) begin
         @(negedge f100m_clk);
         check("t2_hold", {5'd0, res_if.res_valid, busy, res_if.res_flags, res_if.sum_data, res_if.avg_data},
               {5'd0, 1'b1, 1'b1, 3'b000, 12'd406, 10'(ref_avg(406))});
      end
      accept_result();
      check("t2_idle_busy",  32'(busy), 32'd0);
      check("t2_idle_valid", 32'(res_if.res_valid), 32'd0);

      // random bursts, each a fresh start after the previous accept
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 4; i++) c[i] = int'($urandom_range(0, 1023));
         push_burst(c[0], c[1], c[2], c[3], 3'b000);
         pulse_start();
         wait_result("t3", 1'b1);
         accept_result();
         check("t3_idle", 32'(busy), 32'd0);
      end

      // continuous mode with full-scale codes, dropped during second burst
      push_burst(1023, 1023, 1023, 1023, 3'b000);
      push_burst(1023, 1023, 1023, 1023, 3'b000);
      @(posedge f100m_clk); #1 continuous = 1'b1;
      pulse_start();
      wait_result("t4a", 1'b1);
      accept_result();
      check("t4_auto_soc",   32'(sar_soc), 32'd1);
      check("t4_auto_busy",  32'(busy), 32'd1);
      check("t4_auto_valid", 32'(res_if.res_valid), 32'd0);
      @(posedge f100m_clk); #1 continuous = 1'b0;
      wait_result("t4b", 1'b1);
      accept_result();
      check("t4_end_idle", 32'(busy), 32'd0);

      // timeout on the second conversion
      hang_after = 1;
      code_q.push_back(200);
      exp_q.push_back({3'b100, 12'd200, 10'd50});
      pulse_start();
      wait_result("t5", 1'b0);
      accept_result();
      hang_after = -1;
      check("t5_soc_run", 32'(soc_last_run), 32'(TIMEOUT));
      check("t5_idle", 32'(busy), 32'd0);

      // comparator error during conversion 3, then a clean burst
      base = served;
      for (int i = 0; i < 4; i++) c[i] = int'($urandom_range(0, 1023));
      push_burst(c[0], c[1], c[2], c[3], 3'b001);
      pulse_start();
      wait_served(base + 3);
      @(posedge f100m_clk); #1 sar_err = 1'b1;
      @(posedge f100m_clk); #1 sar_err = 1'b0;
      wait_result("t6_err", 1'b1);
      accept_result();
      for (int i = 0; i < 4; i++) c[i] = int'($urandom_range(0, 1023));
      push_burst(c[0], c[1], c[2], c[3], 3'b000);
      pulse_start();
      wait_result("t6_clear", 1'b1);
      accept_result();

      // overflow warning during conversion 1
      base = served;
      for (int i = 0; i < 4; i++) c[i] = int'($urandom_range(0, 1023));
      push_burst(c[0], c[1], c[2], c[3], 3'b010);
      pulse_start();
      wait_served(base + 1);
      @(posedge f100m_clk); #1 sar_warn = 1'b1;
      @(posedge f100m_clk); #1 sar_warn = 1'b0;
      wait_result("t6_warn", 1'b1);
      accept_result();

      // asynchronous reset in the middle of conversion 2
      base = served;
      for (int i = 0; i < 4; i++) c[i] = int'($urandom_range(0, 1023));
      push_burst(c[0], c[1], c[2], c[3], 3'b000);
      pulse_start();
      wait_served(base + 2);
      @(negedge f100m_clk);
      check("t7_pre_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t7_rst_soc",   32'(sar_soc), 32'd0);
      check("t7_rst_valid", 32'(res_if.res_valid), 32'd0);
      check("t7_rst_busy",  32'(busy), 32'd0);
      check("t7_rst_sum",   32'(res_if.sum_data), 32'd0);
      code_q.delete();
      exp_q.delete();
      repeat (3) @(posedge f100m_clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge f100m_clk);
      base = soc_rises;
      for (int i = 0; i < 4; i++) c[i] = int'($urandom_range(0, 1023));
      push_burst(c[0], c[1], c[2], c[3], 3'b000);
      pulse_start();
      wait_result("t7_fresh", 1'b1);
      check("t7_soc_count", 32'(soc_rises - base), 32'd4);
      accept_result();
      check("t7_idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
